pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter W, default 8, data width in bits; SHALL be a power of two, at least 2.
REQ-002 Derived localparam L = $clog2(W); it is the pipeline depth and the shift-amount width.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port up_valid, input, 1 bit: upstream presents an operation.
REQ-006 Port up_ready, output, 1 bit: block can accept an operation this cycle.
REQ-007 Port up_data, input, W bits: operand, treated as unsigned except in SRA mode.
REQ-008 Port up_shamt, input, L bits: shift amount, 0..W-1.
REQ-009 Port up_mode, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 Port down_valid, output, 1 bit: result available.
REQ-011 Port down_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port down_data, output, W bits: shifted result.

Function
REQ-013 Handshake: a transfer occurs on a rising edge when valid and ready are both 1, on the up side and on the down side independently.
REQ-014 Pipeline: L register stages, stage k = 0..L-1; each stage holds valid, data, the remaining shamt bits and mode.
REQ-015 Stage k SHALL apply a shift or rotate of 2^k positions when shamt bit k is 1, and pass the data unchanged when it is 0.
REQ-016 SLL SHALL zero-fill from the LSB side.
REQ-017 SRL SHALL zero-fill from the MSB side.
REQ-018 SRA SHALL fill with the original operand's bit W-1.
REQ-019 ROR SHALL wrap bit 0 into bit W-1; no bits are lost.
REQ-020 Result SHALL equal: a<<s (SLL), a>>s (SRL), $signed(a)>>>s (SRA), (a>>s)|(a<<(W-s)) (ROR, taken as a when s=0), all truncated to W bits.
REQ-021 Stage readiness SHALL be: rdy[L-1] = !valid[L-1] | down_ready; rdy[k] = !valid[k] | rdy[k+1]; up_ready = rdy[0]. The ready path is combinational; no bubble is required.
REQ-022 A stage loads from its predecessor (from the input port for stage 0) when rdy[k] is 1.
REQ-023 A stage's valid becomes 0 when its predecessor is not valid and its own content is consumed.
REQ-024 down_valid = valid[L-1] and down_data = data[L-1], both registered outputs.
REQ-025 Latency: an operation accepted at edge t SHALL be presented on down_valid/down_data after edge t+L-1, when no stall occurs.
REQ-026 Throughput: one operation per cycle while down_ready stays 1.
REQ-027 Backpressure: when down_ready=0, stage contents SHALL hold unchanged; empty stages still fill.
REQ-028 up_ready SHALL drop to 0 only when all L stages are valid and down_ready=0.
REQ-029 Order: results SHALL leave in acceptance order; none dropped or duplicated.
REQ-030 Simultaneous accept and emit on a full pipeline with down_ready=1 SHALL be lossless.
REQ-031 Data, shamt and mode of a stage SHALL NOT change while that stage is valid and stalled.
REQ-032 up_* inputs SHALL be ignored when up_valid=0.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, clear every stage to valid=0, data=0, shamt=0, mode=0.
REQ-034 During reset: down_valid=0, down_data=0, up_ready=1.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operations.
REQ-036 The first transfer after reset is accepted on the first rising edge with rst_n=1.

Verification
REQ-037 Bench SHALL cover, with W=8 (L=3), the following directed scenarios, plus a random scoreboard run against the REQ-020 model.
- Modes: up_data=0xB5, shamt=3, one op per mode, down_ready=1 -> results 0xA8 (SLL), 0x16 (SRL), 0xF6 (SRA), 0xB6 (ROR), each 3 cycles after accept, in order.
- Boundaries: shamt=0 on 0x81 in every mode -> 0x81. shamt=7 on 0x80: SLL 0x00, SRL 0x01, SRA 0xFF, ROR 0x01.
- Backpressure: down_ready=0, up_valid=1 for 5 cycles -> exactly 3 accepted, up_ready=0 afterwards, down_data stable. Then down_ready=1 -> all 3 emerge in order and up_ready returns to 1 in the same cycle.
- Streaming: 16 back-to-back ops with down_ready=1 -> 16 results on consecutive cycles, no gaps after initial latency 3.
- Reset mid-flight: 2 ops in pipeline, rst_n pulsed low between edges -> down_valid=0 immediately; after release no stale result ever appears.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one shift/rotate stage per shamt bit, each stage
// registered, with a combinational ready chain so a full pipe streams without
// bubbles. Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
module pipelined_barrel_shifter #(
  parameter int unsigned W = 8,
  localparam int unsigned L = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  input  logic [L-1:0] up_shamt,
  input  logic [1:0]   up_mode,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [W-1:0] down_data
);

  logic [L-1:0] valid_q;
  logic [W-1:0] data_q  [L];
  logic [L-1:0] shamt_q [L];
  logic [1:0]   mode_q  [L];

  logic [L-1:0] rdy;
  logic [L-1:0] in_valid;
  logic [W-1:0] in_data  [L];
  logic [L-1:0] in_shamt [L];
  logic [1:0]   in_mode  [L];
  logic [W-1:0] data_d   [L];

  // One fixed-distance step; amt is always a power of two below W.
  function automatic logic [W-1:0] shift_step(input logic [W-1:0] d, input logic [1:0] m,
                                              input int unsigned amt);
    logic [W-1:0] r;
    r = d;
    unique case (m)
      2'b00: r = d << amt;
      2'b01: r = d >> amt;
      // MSB is invariant under arithmetic shifts, so it still holds the operand sign.
      2'b10: r = W'($signed(d) >>> amt);
      2'b11: r = (d >> amt) | (d << (W - amt));
    endcase
    return r;
  endfunction

  // Ready chain from the output back to the input; a stage can take new
  // content when it is empty or its content moves on this edge.
  always_comb begin
    rdy = '1;
    rdy[L-1] = !valid_q[L-1] | down_ready;
    for (int k = int'(L) - 2; k >= 0; k--) begin
      rdy[k] = !valid_q[k] | rdy[k+1];
    end
  end

  // Per-stage source selection and the shift applied on the way in.
  always_comb begin
    in_valid    = '0;
    in_valid[0] = up_valid;
    in_data[0]  = up_data;
    in_shamt[0] = up_shamt;
    in_mode[0]  = up_mode;
    for (int k = 1; k < int'(L); k++) begin
      in_valid[k] = valid_q[k-1];
      in_data[k]  = data_q[k-1];
      in_shamt[k] = shamt_q[k-1];
      in_mode[k]  = mode_q[k-1];
    end
    for (int k = 0; k < int'(L); k++) begin
      data_d[k] = in_shamt[k][k] ? shift_step(in_data[k], in_mode[k], 32'd1 << k)
                                 : in_data[k];
    end
  end

  // Stage registers; payload only loads with a valid operation so stalled or
  // idle stages keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(L); k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(L); k++) begin
        if (rdy[k]) begin
          valid_q[k] <= in_valid[k];
          if (in_valid[k]) begin
            data_q[k]  <= data_d[k];
            shamt_q[k] <= in_shamt[k];
            mode_q[k]  <= in_mode[k];
          end
        end
      end
    end
  end

  assign up_ready   = rdy[0];
  assign down_valid = valid_q[L-1];
  assign down_data  = data_q[L-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (W=8): the driver pushes the
// expected result when an operation is accepted, a monitor pops and compares.
module tb_pipelined_barrel_shifter;
  localparam int unsigned W = 8;
  localparam int unsigned L = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic [W-1:0] up_data = '0;
  logic [L-1:0] up_shamt = '0;
  logic [1:0]   up_mode = '0;
  logic         down_valid;
  logic         down_ready = 1'b1;
  logic [W-1:0] down_data;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  cyc;
    bit           strict;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int          n_out = 0;
  bit          rand_bp = 1'b0;

  pipelined_barrel_shifter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_shamt  (up_shamt),
    .up_mode   (up_mode),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference: shifts on a double-width value with plain arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input int s, input logic [1:0] m);
    logic [2*W-1:0] wide;
    case (m)
      2'd0:    wide = {{W{1'b0}}, a} << s;
      2'd1:    wide = {{W{1'b0}}, a} >> s;
      2'd2:    wide = {{W{a[W-1]}}, a} >> s;
      default: wide = {a, a} >> s;
    endcase
    return wide[W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: a result transfers on the next rising edge when valid and ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && down_valid && down_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got %0h required no output", down_data);
      end else begin
        e = exp_q.pop_front();
        check("result", down_data, e.data);
        if (e.strict) check("latency", cyc, e.cyc);
        else check("latency_min", 32'(cyc >= e.cyc), 1);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [L-1:0] s, input logic [1:0] m,
                      input logic [W-1:0] exp, input bit push, input bit strict);
    bit done = 1'b0;
    up_valid = 1'b1;
    up_data  = a;
    up_shamt = s;
    up_mode  = m;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rand_bp) down_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (up_ready) begin
        done = 1'b1;
        if (push) exp_q.push_back('{exp, cyc + L, strict});
      end
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout: got no accept required accept within 64 cycles");
    end
  endtask

  task automatic send_rand(input bit strict);
    logic [W-1:0] a;
    logic [L-1:0] s;
    logic [1:0]   m;
    a = W'($urandom);
    s = L'($urandom);
    m = 2'($urandom);
    send(a, s, m, model(a, int'(s), m), 1'b1, strict);
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    repeat (n) begin
      if (rand_bp) down_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    rand_bp = 1'b0;
    down_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [W-1:0] mode_exp [4] = '{8'hA8, 8'h16, 8'hF6, 8'hB6};
  logic [W-1:0] sh7_exp  [4] = '{8'h00, 8'h01, 8'hFF, 8'h01};

  initial begin
    int           acc;
    int           out0;
    logic [W-1:0] head;
    logic [W-1:0] a;
    logic [L-1:0] s;
    logic [1:0]   m;

    // Reset values, observed with no clock edge involved.
    #1;
    check("rst_down_valid", down_valid, 0);
    check("rst_down_data", down_data, 0);
    check("rst_up_ready", up_ready, 1);
    #7 rst_n = 1'b1;

    // One op per mode on 0xB5 by 3; first accept on the first edge after reset.
    for (int i = 0; i < 4; i++) send(8'hB5, 3'd3, 2'(i), mode_exp[i], 1'b1, 1'b1);
    // Boundary shift amounts.
    for (int i = 0; i < 4; i++) send(8'h81, 3'd0, 2'(i), 8'h81, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(8'h80, 3'd7, 2'(i), sh7_exp[i], 1'b1, 1'b1);
    drain();

    // Backpressure: offer for 5 cycles with the sink stalled.
    down_ready = 1'b0;
    acc = 0;
    head = '0;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      s = L'($urandom);
      m = 2'($urandom);
      up_valid = 1'b1;
      up_data  = a;
      up_shamt = s;
      up_mode  = m;
      @(negedge clk);
      if (up_ready) begin
        if (acc == 0) head = model(a, int'(s), m);
        exp_q.push_back('{model(a, int'(s), m), cyc + L, 1'b0});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    check("bp_accepted", acc, 3);
    check("bp_up_ready_low", up_ready, 0);
    check("bp_down_valid", down_valid, 1);
    check("bp_head", down_data, head);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("bp_head_held", down_data, head);
    check("bp_still_full", up_ready, 0);
    down_ready = 1'b1;
    #1;
    check("bp_ready_return", up_ready, 1);
    drain();

    // Streaming: 16 back-to-back ops, exact latency means no gaps.
    out0 = n_out;
    for (int i = 0; i < 16; i++) send_rand(1'b1);
    drain();
    check("stream_count", n_out - out0, 16);

    // Random run with random gaps and backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_rand(1'b0);
    end
    drain();

    // Reset mid-flight: two ops in the pipe, neither may ever come out.
    down_ready = 1'b0;
    send(8'h5A, 3'd1, 2'd0, 8'h00, 1'b0, 1'b0);
    send(8'hC3, 3'd2, 2'd3, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rf_pre_valid", down_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rf_down_valid", down_valid, 0);
    check("rf_down_data", down_data, 0);
    check("rf_up_ready", up_ready, 1);
    #1 rst_n = 1'b1;
    down_ready = 1'b1;
    out0 = n_out;
    send(8'h3C, 3'd2, 2'd3, 8'h0F, 1'b1, 1'b1);
    idle(10);
    drain();
    check("rf_no_stale", n_out - out0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
